cell_pos_reader: RTL and testbench
==================================

Name: cell_pos_reader

Overview:
- Read-side client for one per-cell position memory (single-port, 2-cycle read latency, address 0 = particle count, words {posz,posy,posx}).
- On `start`, reads the count word, then streams particles 1..count out on a valid/ready interface.
- Feeds the force-evaluation pipeline and the motion-update front end.
- Tracks the memory latency, so downstream backpressure never loses a word.

Parameters:
- DATA_WIDTH, 96, particle word width {posz,posy,posx}, 32 bits each.
- ADDR_WIDTH, 8, cell memory address width.
- PARTICLE_NUM, 220, memory depth in words; max particles = PARTICLE_NUM-1.
- FIFO_DEPTH, 4, output buffer entries; must be >= 3; power of two.

Ports:
- clock  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin a cell scan; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted, or after count=0 is seen.
- particle_count  out  ADDR_WIDTH  count latched from address 0 (after clamping).
- count_err  out  1  sticky until next start; raw count exceeded PARTICLE_NUM-1.
- mem_address  out  ADDR_WIDTH  to cell memory address.
- mem_rden  out  1  read enable.
- mem_wren  out  1  constant 0.
- mem_data  out  DATA_WIDTH  constant 0.
- mem_q  in  DATA_WIDTH  memory read data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  particle position.
- out_index  out  ADDR_WIDTH  memory address the word came from (1..count).
- out_last  out  1  set on the beat with out_index == particle_count.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, FIFO flushed, latency pipe cleared; asserting rst_n low mid-scan aborts immediately with no done pulse.
- Memory timing: a request with mem_rden=1 in cycle N returns data on mem_q in cycle N+2. A 2-stage valid/address shift register tags each returning word; no other latency assumption is made.
- FSM states: IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN.
- IDLE: start=1 -> RD_CNT; clears count_err and particle_count.
- RD_CNT (1 cycle): mem_address=0, mem_rden=1 -> WAIT_CNT.
- WAIT_CNT: when the tagged count word returns (cycle N+2):
  - raw = mem_q[ADDR_WIDTH-1:0]; if raw > PARTICLE_NUM-1, clamp to PARTICLE_NUM-1 and set count_err.
  - If the count is 0, go to FIN; otherwise go to STREAM with next_addr=1.
- STREAM: issue mem_rden=1, mem_address=next_addr when credit holds, then increment next_addr.
  - Credit: fifo_occupancy + in_flight < FIFO_DEPTH, where in_flight = number of set bits in the latency pipe.
  - Once next_addr == count has been issued, go to DRAIN.
- DRAIN: issue no reads; wait until in_flight=0 and the FIFO is empty; the last handshake moves to FIN.
- FIN (1 cycle): done=1 -> IDLE.
- FIFO:
  - Write on tagged return; pop on out_valid && out_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Overflow is impossible by credit; the bench asserts this.
  - out_valid = FIFO non-empty; out_data, out_index and out_last come from the FIFO head and stay stable while valid && !ready.
- Throughput: with out_ready held high, one beat per cycle after the first beat.
- mem_rden is 0 in every cycle the FSM issues no request; mem_address holds its last value.
- start during busy: no effect. start in the same cycle as FIN: ignored, so start must come while in IDLE.

Test Plan:
- Count=3, out_ready=1, start in cycle 0 -> address 0 read in cycle 1, reads of 1,2,3 in cycles 4,5,6, beats in cycles 6,7,8 with out_index 1,2,3 and out_last on 3, done in cycle 9.
- Count=0 -> no out_valid, only address 0 is read, done pulses one cycle after the count returns, particle_count=0.
- Count=10, out_ready toggling 1-0-0-1 -> all 10 beats in order with data equal to the memory contents, never more than 4 outstanding plus buffered, and data stable while stalled.
- Raw count=250, PARTICLE_NUM=220 -> particle_count=219, count_err=1, 219 beats, last read address 219.
- rst_n low during the 5th beat of a 10-particle scan -> outputs 0 immediately, FIFO empty, no done; a new start rescans from address 0.
- start asserted while busy -> ignored: particle_count unchanged, exactly one done pulse.

Source files
------------

// File: rtl/cell_pos_reader.sv
// Read-side client for a per-cell position memory: fetches the particle count
// at address 0, then streams particles 1..count on a valid/ready port.
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] next_addr, addr_q, issue_addr;
  logic                  issue;
  logic [1:0]            pipe_v;
  logic [ADDR_WIDTH-1:0] pipe_a0, pipe_a1;
  logic [ADDR_WIDTH-1:0] raw_cnt, cnt_clamped;
  logic                  cnt_over;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  fifo_empty, ret_valid, fifo_push, fifo_pop, hs;
  logic [1:0]            in_flight;
  logic [OCC_W:0]        pending;
  logic                  has_credit;

  assign raw_cnt     = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over    = raw_cnt > MAX_CNT;
  assign cnt_clamped = cnt_over ? MAX_CNT : raw_cnt;

  assign in_flight  = {1'b0, pipe_v[0]} + {1'b0, pipe_v[1]};
  assign pending    = {1'b0, occ} + (OCC_W+1)'(in_flight);
  assign has_credit = pending < (OCC_W+1)'(FIFO_DEPTH);

  // Address 0 is only ever read as the count word, so it doubles as the tag.
  assign ret_valid  = pipe_v[1] && (pipe_a1 != '0);
  assign fifo_empty = (occ == '0);
  // Returning word bypasses an empty FIFO so the first beat appears on return.
  assign out_valid  = !fifo_empty || ret_valid;
  assign out_data   = !fifo_empty ? fifo_data[rd_ptr] : (ret_valid ? mem_q : '0);
  assign out_index  = !fifo_empty ? fifo_idx[rd_ptr] : (ret_valid ? pipe_a1 : '0);
  assign out_last   = out_valid && (out_index == particle_count);
  assign hs         = out_valid && out_ready;
  assign fifo_pop   = !fifo_empty && out_ready;
  assign fifo_push  = ret_valid && !(fifo_empty && out_ready);

  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign mem_rden    = issue;
  assign mem_address = issue ? issue_addr : addr_q;
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_addr = next_addr;
    case (state)
      IDLE:     if (start) state_nx = RD_CNT;
      RD_CNT: begin
        issue      = 1'b1;
        issue_addr = '0;
        state_nx   = WAIT_CNT;
      end
      WAIT_CNT: if (pipe_v[1]) state_nx = (cnt_clamped == '0) ? FIN : STREAM;
      STREAM: if (has_credit) begin
        issue = 1'b1;
        if (next_addr == particle_count) state_nx = DRAIN;
      end
      DRAIN:    if (hs && out_last) state_nx = FIN;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      next_addr      <= '0;
      addr_q         <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
      pipe_v         <= '0;
      pipe_a0        <= '0;
      pipe_a1        <= '0;
    end else begin
      state   <= state_nx;
      pipe_v  <= {pipe_v[0], issue};
      pipe_a0 <= issue_addr;
      pipe_a1 <= pipe_a0;
      if (issue) addr_q <= issue_addr;
      if (state == IDLE && start) begin
        particle_count <= '0;
        count_err      <= 1'b0;
      end
      if (state == WAIT_CNT && pipe_v[1]) begin
        particle_count <= cnt_clamped;
        count_err      <= cnt_over;
        next_addr      <= ADDR_WIDTH'(1);
      end
      if (state == STREAM && issue) next_addr <= next_addr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      occ <= occ + 1'b1;
      else if (!fifo_push && fifo_pop) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= mem_q;
      fifo_idx[wr_ptr]  <= pipe_a1;
    end
  end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: 2-cycle memory model plus an expected-stream
// queue built from the count word, checked beat by beat.
module tb_cell_pos_reader;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, count_err, mem_rden, mem_wren;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  particle_count, mem_address, out_index;
  logic [95:0] mem_data, mem_q, out_data;

  logic [95:0] mem [256];
  logic [95:0] rd1;
  int          total = 0;
  int          bad   = 0;

  cell_pos_reader #(.DATA_WIDTH(96), .ADDR_WIDTH(8), .PARTICLE_NUM(220), .FIFO_DEPTH(4)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .count_err(count_err),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  always #5 clock = ~clock;

  // Two register stages: request in cycle N is visible on mem_q in cycle N+2.
  always @(posedge clock) begin
    rd1   <= mem_rden ? mem[mem_address] : {$urandom, $urandom, $urandom};
    mem_q <= rd1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, mem_rden, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_pcount"}, particle_count, 0);
    chk({tag, "_cerr"}, count_err, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  // mode 0: ready always high (cycle-exact timing checked); 1: 1-0-0-1; 2: random.
  task automatic scan(input int unsigned raw, input int unsigned mode,
                      input int unsigned abort_beat, input bit extra_start);
    int unsigned exp_cnt, next_rd, beats, reads, dones, done_cyc;
    int          q[$];
    int          exp_i;
    bit          finished, stalled;
    logic [95:0] w, held_d;
    logic [7:0]  held_i;

    exp_cnt = (raw > 219) ? 219 : raw;
    w = {$urandom, $urandom, $urandom};
    w[7:0] = raw[7:0];
    mem[0] = w;
    for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    for (int i = 1; i <= int'(exp_cnt); i++) q.push_back(i);
    next_rd = 0; beats = 0; reads = 0; dones = 0;
    finished = 0; stalled = 0; held_d = '0; held_i = '0;
    done_cyc = (exp_cnt == 0) ? 4 : 6 + exp_cnt;

    for (int unsigned c = 0; c < 3000 && !finished; c++) begin
      @(posedge clock); #1;
      start = (c == 0) || (extra_start && (c == 5 || c == 10 || (mode == 0 && c == done_cyc)));
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clock);

      if (abort_beat != 0 && out_valid && beats == abort_beat - 1) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        chk("abort_no_done", dones, 0);
        @(negedge clock);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        chk("abort_fifo_empty", out_valid, 0);
        return;
      end

      chk("busy", busy, (c >= 1) ? 1 : 0);

      if (mem_rden) begin
        chk("rd_addr", mem_address, (next_rd <= exp_cnt) ? next_rd : 'h1FF);
        if (mode == 0) chk("rd_cycle", c, (next_rd == 0) ? 1 : 3 + next_rd);
        if (next_rd > 0) begin
          reads++;
          total++;
          assert (reads - beats <= 4) else begin
            bad++;
            $error("FAIL outstanding observed=%0d expected<=4", reads - beats);
          end
        end
        next_rd++;
      end

      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_d);
        chk("stall_index", out_index, held_i);
      end
      stalled = 0;

      if (out_valid && out_ready) begin
        exp_i = (q.size() > 0) ? q.pop_front() : 'h1FF;
        chk("beat_index", out_index, exp_i);
        chk("beat_data", out_data, mem[exp_i & 255]);
        chk("beat_last", out_last, (exp_i == int'(exp_cnt)) ? 1 : 0);
        if (mode == 0) chk("beat_cycle", c, 5 + exp_i);
        beats++;
      end else if (out_valid) begin
        stalled = 1;
        held_d  = out_data;
        held_i  = out_index;
      end

      if (done) begin
        dones++;
        finished = 1;
        chk("done_all_beats", q.size(), 0);
        chk("done_all_reads", next_rd, exp_cnt + 1);
        chk("pcount", particle_count, exp_cnt);
        chk("count_err", count_err, (raw > 219) ? 1 : 0);
        if (mode == 0) chk("done_cycle", c, done_cyc);
      end
    end
    chk("scan_finished", finished, 1);

    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("post_rden", mem_rden, 0);
      chk("post_valid", out_valid, 0);
      chk("post_pcount", particle_count, exp_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #12;
    chk_idle_outputs("reset");
    chk("reset_wren", mem_wren, 0);
    chk("reset_mdata", mem_data, 0);
    @(negedge clock);
    rst_n = 1'b1;

    scan(3, 0, 0, 1'b1);
    scan(0, 0, 0, 1'b0);
    scan(10, 1, 0, 1'b0);
    scan(250, 0, 0, 1'b0);
    scan(10, 0, 5, 1'b0);
    scan(10, 0, 0, 1'b0);
    for (int r = 0; r < 4; r++) scan($urandom_range(1, 40), 2, 0, 1'b0);
    scan(219, 2, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
